// File: rtl/mem_access.sv
// Memory-access stage: byte-serial loads/stores over an 8-bit controller port, registered write-back.
// Optional MEM_EARLY_REQ_EN: issue the byte-0 request from IDLE in the same cycle the op is seen.
module mem_access (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        valid_in,
    input  logic        isLoad_in,
    input  logic        isStore_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] aluResult_in,
    input  logic [31:0] storeData_in,
    input  logic        writeE_in,
    input  logic [4:0]  rd_in,
    output logic        memReq_out,
    output logic        memWr_out,
    output logic [31:0] memAddr_out,
    output logic [7:0]  memWData_out,
    input  logic        memGnt_in,
    input  logic [7:0]  memRData_in,
    output logic        stall_out,
    output logic        writeE_out,
    output logic [4:0]  writeIdx_out,
    output logic [31:0] writeData_out
);
    typedef enum logic [1:0] {IDLE, REQ, TAIL} state_t;

    state_t      state;
    logic [1:0]  cnt;
    logic [23:0] asm_buf;
    logic        rd_pend;

    logic        mem_op;
    logic        is_store;
    logic        early_req;
    logic        req;
    logic [1:0]  last_idx;
    logic [7:0]  wr_byte;
    logic [31:0] load_value;

    assign mem_op   = valid_in & (isLoad_in | isStore_in);
    assign is_store = isStore_in & ~isLoad_in;
    assign last_idx = {funct3_in[1], funct3_in[1] | funct3_in[0]};

`ifdef MEM_EARLY_REQ_EN
    assign early_req = (state == IDLE) & mem_op;
`else
    assign early_req = 1'b0;
`endif

    assign req          = ~rst_in & ((state == REQ) | early_req);
    assign memReq_out   = req;
    assign memWr_out    = req & is_store;
    assign memAddr_out  = req ? aluResult_in + {30'd0, cnt} : 32'd0;
    assign memWData_out = (req & is_store) ? wr_byte : 8'd0;
    assign stall_out    = ~rst_in & (((state == IDLE) & mem_op) | (state == REQ));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_byte = storeData_in[7:0];
        case (cnt)
            2'd1:    wr_byte = storeData_in[15:8];
            2'd2:    wr_byte = storeData_in[23:16];
            2'd3:    wr_byte = storeData_in[31:24];
            default: wr_byte = storeData_in[7:0];
        endcase
    end

    // The final byte is never buffered: it arrives on memRData_in during TAIL.
    always_comb begin
        load_value = {memRData_in, asm_buf};
        case (last_idx)
            2'd0:    load_value = {{24{~funct3_in[2] & memRData_in[7]}}, memRData_in};
            2'd1:    load_value = {{16{~funct3_in[2] & memRData_in[7]}}, memRData_in, asm_buf[7:0]};
            default: load_value = {memRData_in, asm_buf};
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            // NOTE: the assembly buffer is reset too; it is small and a clean value eases debug.
            state         <= IDLE;
            cnt           <= 2'd0;
            asm_buf       <= 24'd0;
            rd_pend       <= 1'b0;
            writeE_out    <= 1'b0;
            writeIdx_out  <= 5'd0;
            writeData_out <= 32'd0;
        end else begin
            // Read data trails its grant by one cycle, independent of the current grant.
            rd_pend <= req & memGnt_in & ~is_store;
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        writeE_out <= 1'b0;
`ifdef MEM_EARLY_REQ_EN
                        if (memGnt_in) begin
                            state <= (last_idx == 2'd0) ? TAIL : REQ;
                            cnt   <= (last_idx == 2'd0) ? 2'd0 : 2'd1;
                        end else begin
                            state <= REQ;
                            cnt   <= 2'd0;
                        end
`else
                        state <= REQ;
                        cnt   <= 2'd0;
`endif
                    end else begin
                        writeE_out    <= valid_in & writeE_in;
                        writeIdx_out  <= rd_in;
                        writeData_out <= aluResult_in;
                    end
                end
                REQ: begin
                    writeE_out <= 1'b0;
                    if (rd_pend) begin
                        case (cnt)
                            2'd1:    asm_buf[7:0]   <= memRData_in;
                            2'd2:    asm_buf[15:8]  <= memRData_in;
                            2'd3:    asm_buf[23:16] <= memRData_in;
                            default: ;
                        endcase
                    end
                    if (memGnt_in) begin
                        if (cnt == last_idx) begin
                            state <= TAIL;
                            cnt   <= 2'd0;
                        end else begin
                            cnt <= cnt + 2'd1;
                        end
                    end
                end
                TAIL: begin
                    state <= IDLE;
                    cnt   <= 2'd0;
                    if (is_store) begin
                        writeE_out <= 1'b0;
                    end else begin
                        writeE_out    <= writeE_in;
                        writeIdx_out  <= rd_in;
                        writeData_out <= load_value;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 2'd0;
                end
            endcase
        end
    end
endmodule
